// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, default receive FIFO depth and the byte type
// used by the receiver, transmitter and Wishbone bridge.
package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int UART_FIFO_DEPTH_LOG2 = 4;

   typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read. Kept free of reset
// and read registers so it maps onto distributed RAM.
module fifo_ram #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 4
)(
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] mem [2**ADDR_W];

   // NOTE: the array has no reset; a reset would block RAM inference, and the FIFO
   // never exposes an entry that has not been written since the last reset.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO between the UART receiver and the Wishbone bridge,
// with a sticky overflow flag. Define UART_RX_FIFO_ALMOST_FULL_EN to add o_almost_full.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
   parameter int DATA_W     = UART_DATA_W
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,parameter int AFULL_LEVEL = (1 << DEPTH_LOG2) - 4
`endif
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [DATA_W-1:0]     i_dat,
   input  logic                  i_wr,
   output logic [DATA_W-1:0]     o_dat,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_full,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_overflow,
   input  logic                  i_ovf_clr
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,output logic                 o_almost_full
`endif
);

   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  valid, full, push, pop, drop;
   logic [DATA_W-1:0]     ram_rdata;

   // Status flags come only from the count register, never from i_wr.
   assign valid = (count_q != '0);
   assign full  = (count_q == FULL_CNT);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      pop  = valid && i_ready;
      push = i_wr && (!full || pop);
      drop = i_wr && full && !pop;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
         overflow_d = 1'b1;
      end else if (i_ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of evaluation order.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   fifo_ram #(
      .WIDTH  (DATA_W),
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (push),
      .i_waddr (wr_ptr_q),
      .i_wdata (i_dat),
      .i_raddr (rd_ptr_q),
      .o_rdata (ram_rdata)
   );

   // Masked while empty so stale storage never reaches the bridge.
   assign o_dat      = valid ? ram_rdata : '0;
   assign o_valid    = valid;
   assign o_full     = full;
   assign o_count    = count_q;
   assign o_overflow = overflow_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   localparam logic [DEPTH_LOG2:0] AFULL_CNT = AFULL_LEVEL[DEPTH_LOG2:0];

   logic almost_full_q, almost_full_d;

   assign almost_full_d = (count_d >= AFULL_CNT);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         almost_full_q <= 1'b0;
      end else begin
         almost_full_q <= almost_full_d;
      end
   end

   assign o_almost_full = almost_full_q;
`endif

endmodule
